// File: rtl/uart_baud_if.sv
// Baud controller bundle: divisor handshake, run/sync
// controls and the tick outputs shared with TX/RX.
interface uart_baud_if #(
    parameter int DIV_W = 16
);
    logic             en;
    logic             cfg_valid;
    logic [DIV_W-1:0] cfg_div;
    logic             cfg_ready;
    logic             cfg_err;
    logic             sync_req;
    logic             os_tick;
    logic             bit_tick;
    logic [DIV_W-1:0] cur_div;

    modport master (
        output en, cfg_valid, cfg_div, sync_req,
        input  cfg_ready, cfg_err, os_tick, bit_tick, cur_div
    );

    modport slave (
        input  en, cfg_valid, cfg_div, sync_req,
        output cfg_ready, cfg_err, os_tick, bit_tick, cur_div
    );
endinterface

// File: rtl/uart_baud_ctrl.sv
// Baud tick generator with glitch-free divisor updates
// applied on bit boundaries and mid-bit phase realignment.
module uart_baud_ctrl #(
    parameter int DIV_W       = 16,
    parameter int OVS         = 16,
    parameter int DEFAULT_DIV = 163
) (
    input  logic        clk,
    input  logic        rst,
    uart_baud_if.slave  b
);
    localparam int OS_W = $clog2(OVS);
    localparam logic [OS_W-1:0] OS_LAST = OS_W'(OVS - 1);
    localparam logic [OS_W-1:0] OS_HALF = OS_W'(OVS / 2);

    typedef enum logic {IDLE, RUN} state_t;

    state_t           state_q, state_d;
    logic [DIV_W-1:0] cnt_q, cnt_d;
    logic [OS_W-1:0]  os_cnt_q, os_cnt_d;
    logic [DIV_W-1:0] cur_div_q, cur_div_d;
    logic [DIV_W-1:0] pend_div_q, pend_div_d;
    logic             pend_q, pend_d;
    logic             os_tick_q, os_tick_d;
    logic             bit_tick_q, bit_tick_d;
    logic             cfg_err_q, cfg_err_d;
    logic             cfg_ready_q, cfg_ready_d;

    logic xfer;
    logic bad_div;
    logic wrap;
    logic apply_evt;

    assign xfer    = b.cfg_valid && cfg_ready_q;
    assign bad_div = b.cfg_div < DIV_W'(2);
    assign wrap    = cnt_q == (cur_div_q - DIV_W'(1));

    // Next-state: counters, ticks and divisor hand-over
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        os_cnt_d   = os_cnt_q;
        cur_div_d  = cur_div_q;
        pend_div_d = pend_div_q;
        pend_d     = pend_q;
        os_tick_d  = 1'b0;
        bit_tick_d = 1'b0;
        apply_evt  = 1'b0;
        cfg_err_d  = xfer && bad_div;

        unique case (state_q)
            IDLE: begin
                cnt_d    = '0;
                os_cnt_d = '0;
                if (b.en) begin
                    state_d = RUN;
                end
                if (xfer && !bad_div) begin
                    cur_div_d = b.cfg_div;
                end
            end
            RUN: begin
                if (!b.en) begin
                    state_d   = IDLE;
                    cnt_d     = '0;
                    os_cnt_d  = '0;
                    apply_evt = 1'b1;
                end else if (b.sync_req) begin
                    cnt_d     = '0;
                    os_cnt_d  = OS_HALF;
                    apply_evt = 1'b1;
                end else if (wrap) begin
                    cnt_d     = '0;
                    os_tick_d = 1'b1;
                    if (os_cnt_q == OS_LAST) begin
                        os_cnt_d   = '0;
                        bit_tick_d = 1'b1;
                        apply_evt  = 1'b1;
                    end else begin
                        os_cnt_d = os_cnt_q + OS_W'(1);
                    end
                end else begin
                    cnt_d = cnt_q + DIV_W'(1);
                end

                if (apply_evt && pend_q) begin
                    cur_div_d = pend_div_q;
                    pend_d    = 1'b0;
                end
                // A request landing on a boundary edge takes effect at once
                if (xfer && !bad_div) begin
                    if (apply_evt) begin
                        cur_div_d = b.cfg_div;
                    end else begin
                        pend_div_d = b.cfg_div;
                        pend_d     = 1'b1;
                    end
                end
            end
        endcase

        cfg_ready_d = !pend_d && !(apply_evt && pend_q);
    end

    // State and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            os_cnt_q    <= '0;
            cur_div_q   <= DIV_W'(DEFAULT_DIV);
            pend_div_q  <= '0;
            pend_q      <= 1'b0;
            os_tick_q   <= 1'b0;
            bit_tick_q  <= 1'b0;
            cfg_err_q   <= 1'b0;
            cfg_ready_q <= 1'b1;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            os_cnt_q    <= os_cnt_d;
            cur_div_q   <= cur_div_d;
            pend_div_q  <= pend_div_d;
            pend_q      <= pend_d;
            os_tick_q   <= os_tick_d;
            bit_tick_q  <= bit_tick_d;
            cfg_err_q   <= cfg_err_d;
            cfg_ready_q <= cfg_ready_d;
        end
    end

    assign b.os_tick   = os_tick_q;
    assign b.bit_tick  = bit_tick_q;
    assign b.cfg_err   = cfg_err_q;
    assign b.cfg_ready = cfg_ready_q;
    assign b.cur_div   = cur_div_q;
endmodule

// File: doc/uart_baud_ctrl.md
Name: uart_baud_ctrl

Overview:
Programmable baud-tick controller for the UART. It owns the divisor configuration and sequences the baud counter. It produces a 1-cycle oversample tick (`os_tick`) and a 1-cycle bit tick (`bit_tick`) for the TX/RX FSMs. It also accepts divisor updates through a valid/ready handshake, applying them glitch-free on a bit boundary, and realigns phase to mid-bit on request from the RX start-bit detector.

Parameters:
DIV_W, 16, width of the divisor and cycle counter
OVS, 16, oversample ticks per bit (even, >=2)
DEFAULT_DIV, 163, reset divisor: clk cycles per os_tick (50 MHz / (19200*16))

Ports:
clk  in  1  clock
rst  in  1  reset
en  in  1  run enable; 0 = counters held, no ticks
cfg_valid  in  1  divisor update request
cfg_div  in  DIV_W  requested divisor (cycles per os_tick)
cfg_ready  out  1  1 = no update pending, handshake can complete
cfg_err  out  1  1-cycle pulse: rejected divisor (<2)
sync_req  in  1  realign phase so bit_tick lands mid-bit (RX start edge)
os_tick  out  1  1-cycle oversample tick
bit_tick  out  1  1-cycle bit tick, coincident with every OVS-th os_tick
cur_div  out  DIV_W  divisor currently in use

Behaviour:
- Reset is synchronous and active-high on rst; clock is clk. rst has priority over all other inputs.
- Reset values:
  - State IDLE; cnt=0, os_cnt=0, cur_div=DEFAULT_DIV, pending cleared.
  - os_tick=0, bit_tick=0, cfg_err=0, cfg_ready=1.
- Reset mid-operation discards any pending divisor.
- Registers:
  - cnt: DIV_W bits, counts 0..cur_div-1.
  - os_cnt: ceil(log2 OVS) bits, counts 0..OVS-1.
  - pend_div and pend flag.
- All outputs are registered.
- States:
  - IDLE:
    - cnt and os_cnt held at 0; no ticks.
    - en=1 -> RUN at the next edge.
    - sync_req is ignored.
  - RUN:
    - cnt increments each cycle.
    - When cnt==cur_div-1: cnt<=0 and os_tick<=1 for the next cycle.
    - The same event advances os_cnt. If os_cnt==OVS-1, os_cnt wraps to 0 and bit_tick<=1 in the same cycle as os_tick.
    - en=0 -> IDLE at the next edge: counters cleared, any coincident tick suppressed.
- Latency:
  - With en first sampled 1 in cycle 0, the first os_tick is in cycle cur_div+1.
  - os_tick period is then exactly cur_div cycles.
  - The first bit_tick is the OVS-th os_tick.
- sync_req in RUN:
  - cnt<=0, os_cnt<=OVS/2.
  - Overrides a coincident wrap: no tick that cycle.
  - Next os_tick at t+cur_div+1; next bit_tick OVS/2 os_ticks later.
- Config handshake:
  - Transfer occurs when cfg_valid && cfg_ready.
  - cfg_div<2:
    - Rejected; cfg_err=1 the next cycle for exactly 1 cycle.
    - cur_div unchanged; cfg_ready stays 1.
  - Valid divisor while in IDLE: cur_div<=cfg_div at the next edge; cfg_ready stays 1.
  - Valid divisor while in RUN:
    - pend_div<=cfg_div, pend<=1, cfg_ready=0.
    - Applied (cur_div<=pend_div, pend<=0) at the earliest of these edges:
      - the edge generating bit_tick;
      - the edge taking a sync_req;
      - the edge leaving RUN for IDLE.
    - The new divisor governs the count starting at cnt=0 after that edge.
    - cfg_ready returns to 1 the cycle after application.
  - cfg_valid while cfg_ready=0: no transfer; the requester must hold it.
- Width rules:
  - cnt compare uses cur_div-1 in DIV_W bits; the divisor is never <2, so there is no underflow.
  - cur_div updates never occur mid-count, so a tick period is never shortened or stretched.

Test Plan:
1. DEFAULT_DIV=4, OVS=4; rst, then en=1 from cycle 0 -> os_tick in cycles 5, 9, 13, 17; bit_tick only in cycle 17, then every 16 cycles.
2. Running as in (1); cfg_div=6 accepted in cycle 7 -> cfg_ready=0 from cycle 8; os period stays 4 through the bit_tick in cycle 17; next os_tick in cycle 23; cur_div=6 and cfg_ready=1 in cycle 18.
3. cfg_div=1 with cfg_valid in IDLE or RUN -> cfg_err=1 for exactly the next cycle; cur_div unchanged; tick timing unaffected.
4. DIV=4, OVS=4, sync_req in cycle t while running -> no tick in cycle t+1; os_tick in cycle t+5; bit_tick with os_tick in cycle t+9.
5. en dropped mid-count -> no ticks while low; re-enable in cycle u -> first os_tick in cycle u+cur_div+1, and os_cnt restarts from 0.
6. Pending cfg (cfg_ready=0), then rst -> cur_div=DEFAULT_DIV, cfg_ready=1, os_tick=0, bit_tick=0; the pending divisor is never applied.
